// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader FSM states, header byte order and depth default
package prog_loader_pkg;
  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int LEN_LO_SHIFT = 0;
  localparam int LEN_HI_SHIFT = 8;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: packs little-endian byte lanes into a 32-bit word and flags completion
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        full
);
  logic [1:0] lane;
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane <= '0;
      word <= '0;
      full <= 1'b0;
    end else begin
      full <= en && lane == 2'd3;
      if (en) begin
        word[{lane, 3'b000} +: 8] <= data;
        lane <= lane + 2'd1;
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checksummed byte image into instruction memory, then releases the core
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_enable,
  output logic              done,
  output logic              err
);
  state_t state, state_n;
  logic [15:0] len, n_hdr;
  logic [7:0] csum;
  logic [ADDR_W-1:0] idx;
  logic accept, full, last, bad_len;
  assign rx_ready = rst && !full && (state == HDR0 || state == HDR1 || state == DATA || state == CSUM);
  assign accept = rx_valid && rx_ready;
  assign n_hdr = (16'(rx_data) << LEN_HI_SHIFT) | len;
  assign bad_len = n_hdr == 16'd0 || 32'(n_hdr) > DEPTH_WORDS;
  assign last = idx == ADDR_W'(len - 16'd1);
  assign imem_we = full;
  assign imem_addr = idx;
  assign core_enable = state == RUN;
  assign done = state == RUN;
  assign err = state == ERR;
  byte_packer u_pack (
    .clk  (clk),
    .rst  (rst),
    .en   (accept && state == DATA),
    .data (rx_data),
    .word (imem_wdata),
    .full (full)
  );
  always_comb begin
    state_n = state;
    case (state)
      HDR0:    state_n = accept ? HDR1 : HDR0;
      HDR1:    state_n = accept ? (bad_len ? ERR : DATA) : HDR1;
      DATA:    state_n = (full && last) ? CSUM : DATA;
      CSUM:    state_n = accept ? (rx_data == csum ? RUN : ERR) : CSUM;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HDR0;
      len   <= '0;
      csum  <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      if (accept && state == HDR0) len <= 16'(rx_data) << LEN_LO_SHIFT;
      if (accept && state == HDR1) len <= n_hdr;
      if (accept && state == DATA) csum <= csum ^ rx_data;
      if (full && !last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed image loads checked against a byte-stream scoreboard model
module tb_prog_loader;
  logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, imem_we, core_enable, done, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  int checks = 0, errors = 0;
  logic [39:0] expq[$];
  logic [31:0] img[256];
  logic [31:0] last_wdata = '0;
  logic [7:0] model_cs;
  prog_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_enable(core_enable), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && imem_we) begin
      last_wdata = imem_wdata;
      chk("ready_during_we", 64'(rx_ready), 64'd0);
      if (expq.size() == 0) chk("unexpected_we", 64'(imem_we), 64'd0);
      else chk("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(expq.pop_front()));
    end
  end
  task automatic send(logic [7:0] b, int gap);
    int t = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake byte=%h ready stuck low", b);
    end else @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_flags", 64'({core_enable, done, err}), 64'd0);
    rst = 1'b1;
  endtask
  task automatic load(int n, logic [7:0] flip, int gap);
    logic [7:0] cs = 8'h00;
    logic [31:0] w;
    send(n[7:0], gap);
    send(n[15:8], gap);
    if (n >= 1 && n <= 256) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        expq.push_back({i[7:0], w});
        for (int k = 0; k < 4; k++) begin
          cs ^= w[8*k +: 8];
          send(w[8*k +: 8], gap);
        end
      end
      send(cs ^ flip, gap);
    end
    model_cs = cs;
  endtask
  task automatic expect_end(string name, logic run);
    repeat (3) @(negedge clk);
    chk({name, "_done"}, 64'(done), 64'(run));
    chk({name, "_core_enable"}, 64'(core_enable), 64'(run));
    chk({name, "_err"}, 64'(err), 64'(!run));
    chk({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({name, "_pending_writes"}, 64'(expq.size()), 64'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] w;
    do_reset();
    @(negedge clk);
    chk("ready_after_reset", 64'(rx_ready), 64'd1);
    img[0] = 32'h00A00513;
    load(1, 8'h00, 0);
    expect_end("single", 1'b1);
    chk("lit_wdata", 64'(last_wdata), 64'h00A00513);
    chk("lit_csum", 64'(model_cs), 64'hB6);
    chk("lit_addr", 64'(imem_addr), 64'd0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (4) begin
      @(negedge clk);
      chk("run_ignores_rx", 64'({rx_ready, done}), 64'b01);
    end
    rx_valid = 1'b0;
    do_reset();
    img[0] = 32'h11223344;
    img[1] = 32'hDEADBEEF;
    img[2] = 32'h0BADF00D;
    load(3, 8'h00, 1);
    expect_end("three_gapped", 1'b1);
    do_reset();
    load(0, 8'h00, 0);
    expect_end("len_zero", 1'b0);
    do_reset();
    load(257, 8'h00, 0);
    expect_end("len_257", 1'b0);
    do_reset();
    img[0] = 32'hCAFEBABE;
    img[1] = 32'h12345678;
    load(2, 8'h01, 0);
    expect_end("bad_csum", 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) img[i] = 32'hF0E0D0C0 + i;
    send(8'h04, 0);
    send(8'h00, 0);
    expq.push_back({8'd0, img[0]});
    for (int j = 0; j < 6; j++) begin
      w = img[j / 4];
      send(w[8*(j % 4) +: 8], 0);
    end
    repeat (2) @(negedge clk);
    chk("abort_pending_writes", 64'(expq.size()), 64'd0);
    do_reset();
    img[0] = 32'h01020304;
    img[1] = 32'hA5A55A5A;
    load(2, 8'h00, 0);
    expect_end("reload", 1'b1);
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = (32'h01010101 * i) ^ 32'h5A000000;
    load(256, 8'h00, 0);
    expect_end("full_depth", 1'b1);
    chk("full_depth_last_addr", 64'(imem_addr), 64'd255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, default 256, instruction-memory capacity in 32-bit words.
REQ-002 Parameter: ADDR_W, default 8, instruction-memory word-address width; DEPTH_WORDS SHALL equal 2**ADDR_W.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-low.
REQ-005 Port: rx_valid  input  1  byte-stream valid from upstream serial receiver.
REQ-006 Port: rx_data  input  8  byte-stream payload.
REQ-007 Port: rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-008 Port: imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 Port: imem_addr  output  ADDR_W  word address; maps to the core PC bits [ADDR_W+1:2].
REQ-010 Port: imem_wdata  output  32  assembled instruction word.
REQ-011 Port: core_enable  output  1  high releases the processor core and instruction-memory fetch.
REQ-012 Port: done  output  1  image loaded and verified.
REQ-013 Port: err  output  1  image rejected; sticky.

Function
REQ-014 Image format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian, byte 0 = bits [7:0]), then one checksum byte.
REQ-015 FSM states SHALL be HDR0, HDR1, DATA, CSUM, RUN, ERR.
REQ-016 HDR0: accept LEN_LO -> HDR1. HDR1: accept LEN_HI; N==0 or N>DEPTH_WORDS -> ERR, else -> DATA.
REQ-017 DATA: a 2-bit byte counter SHALL select the lane written into a 32-bit assembly register; the counter wraps 3->0.
REQ-018 On acceptance of byte lane 3, imem_we SHALL pulse high for exactly the following cycle, with imem_wdata = assembled word and imem_addr = current word index.
REQ-019 Word index SHALL start at 0, increment after each write, and never exceed N-1; after the write of word N-1 the FSM SHALL move to CSUM.
REQ-020 Checksum SHALL be the running XOR of all 4*N payload bytes (header excluded).
REQ-021 CSUM: accept one byte; match -> RUN, mismatch -> ERR.
REQ-022 rx_ready SHALL be high in HDR0, HDR1, DATA, CSUM; low in RUN and ERR; low in the imem_we cycle (one-cycle back-pressure per word).
REQ-023 RUN: core_enable=1, done=1; terminal until reset; further rx bytes ignored.
REQ-024 ERR: err=1, core_enable=0, done=0; terminal until reset.
REQ-025 core_enable SHALL be 0 in every state except RUN.
REQ-026 rx_valid low SHALL stall the FSM with no state change; gaps between bytes of any length are legal.
REQ-027 imem_we SHALL never assert outside DATA-derived write cycles.

Reset
REQ-028 rst low at a clock edge SHALL force: state HDR0, byte counter 0, word index 0, checksum 0, assembly register 0, imem_we 0, imem_addr 0, imem_wdata 0, core_enable 0, done 0, err 0, rx_ready 0 during reset.
REQ-029 Reset mid-load SHALL discard the partial word; words already written to memory are not cleared.
REQ-030 Reset while in RUN SHALL drop core_enable on the same edge and restart at HDR0.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, the header/checksum byte-order constants and DEPTH_WORDS default.
REQ-032 One sub-module, byte_packer (lane counter + 32-bit assembly register + word-complete flag), is natural; everything else lives in prog_loader.

Verification
REQ-033 Stream 01 00 | 13 05 A0 00 | checksum B6 -> one imem_we, addr 0, wdata 0x00A00513; then done=1, core_enable=1.
REQ-034 N=3 words with rx_valid toggling every other cycle -> writes to addr 0,1,2 in order, correct data, RUN reached.
REQ-035 Header 00 00 -> err=1 after LEN_HI accepted; no imem_we ever; rx_ready=0 afterwards.
REQ-036 Header 01 01 (N=257, DEPTH_WORDS=256) -> ERR, no imem_we.
REQ-037 Valid 2-word image with checksum byte flipped (XOR 0x01) -> both words written, then err=1, core_enable stays 0.
REQ-038 rst low after 6 payload bytes of a 4-word image, then full valid image -> word 0 rewritten from fresh data starting at addr 0, done=1.
